// File: rtl/spi_pattern_gen.sv
// Burst pattern source for the SPI transmitter bench: emits burst_len words over
// a valid/ready handshake, each from a counter, LFSR, walking-one or constant pattern.
module spi_pattern_gen #(
    parameter int                        P_DATA_WIDTH = 8,
    parameter int                        P_BURST_MAX  = 16,
    parameter logic [P_DATA_WIDTH-1:0]   P_LFSR_TAPS  = 8'hB8,
    localparam int                       BW           = $clog2(P_BURST_MAX + 1)
) (
    input  logic                    clk_100,
    input  logic                    s_rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [P_DATA_WIDTH-1:0] seed,
    input  logic [P_DATA_WIDTH-1:0] step,
    input  logic [BW-1:0]           burst_len,
    input  logic                    ready,
    output logic                    valid,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    last,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [P_DATA_WIDTH-1:0] ONE     = {{(P_DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]           LEN_MAX = BW'(P_BURST_MAX);

    function automatic logic is_onehot(input logic [P_DATA_WIDTH-1:0] s);
        return (s != '0) && ((s & (s - ONE)) == '0);
    endfunction

    // Zero would lock the LFSR; walking-one needs exactly one set bit.
    function automatic logic [P_DATA_WIDTH-1:0] seed_fix(input logic [1:0]              m,
                                                        input logic [P_DATA_WIDTH-1:0] s);
        logic [P_DATA_WIDTH-1:0] r;
        case (m)
            2'd1:    r = (s == '0) ? ONE : s;
            2'd2:    r = is_onehot(s) ? s : ONE;
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic logic [P_DATA_WIDTH-1:0] pat_next(input logic [1:0]              m,
                                                        input logic [P_DATA_WIDTH-1:0] p,
                                                        input logic [P_DATA_WIDTH-1:0] st);
        logic [P_DATA_WIDTH-1:0] r;
        case (m)
            2'd0:    r = p + st;
            2'd1:    r = (p >> 1) ^ (p[0] ? P_LFSR_TAPS : '0);
            2'd2:    r = {p[P_DATA_WIDTH-2:0], p[P_DATA_WIDTH-1]};
            default: r = p;
        endcase
        return r;
    endfunction

    state_e                  state_q, state_d;
    logic [P_DATA_WIDTH-1:0] pat_q, pat_d;
    logic [P_DATA_WIDTH-1:0] step_q, step_d;
    logic [1:0]              mode_q, mode_d;
    logic [BW-1:0]           len_q, len_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // State and output registers; reset overrides everything, including a running burst.
    always_ff @(posedge clk_100) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            step_q  <= '0;
            mode_q  <= 2'd0;
            len_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, burst bookkeeping and pattern advance.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        step_d  = step_q;
        mode_d  = mode_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (start && (burst_len != '0)) begin
                    mode_d  = mode;
                    step_d  = step;
                    len_d   = (burst_len > LEN_MAX) ? LEN_MAX : burst_len;
                    pat_d   = seed_fix(mode, seed);
                    beat_d  = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (ready) begin
                    beat_d  = beat_q + BW'(1);
                    pat_d   = pat_next(mode_q, pat_q, step_q);
                    state_d = (beat_q == len_q - BW'(1)) ? ST_DONE : ST_SEND;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next-state values so they leave the block from flops.
    always_comb begin
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        last_d  = (state_d == ST_SEND) && (beat_d == len_d - BW'(1));
    end

    assign valid = valid_q;
    assign data  = pat_q;
    assign last  = last_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_spi_pattern_gen.sv
// Scoreboard bench for spi_pattern_gen: expected words are queued when a burst
// is requested and compared against every valid&&ready transfer.
module tb_spi_pattern_gen;

    logic       clk_100 = 1'b0;
    logic       s_rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] seed = 8'h00;
    logic [7:0] step = 8'h00;
    logic [4:0] burst_len = 5'd0;
    logic       ready = 1'b0;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       busy;
    logic       done;

    spi_pattern_gen dut (
        .clk_100  (clk_100),
        .s_rst    (s_rst),
        .start    (start),
        .mode     (mode),
        .seed     (seed),
        .step     (step),
        .burst_len(burst_len),
        .ready    (ready),
        .valid    (valid),
        .data     (data),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_100 = ~clk_100;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         last_xfer_cyc = -10;
    logic [8:0] exp_q[$];
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge clk_100) cyc <= cyc + 1;

    // Transfer monitor: scoreboard compare, handshake stability and done latency.
    always @(negedge clk_100) begin
        if (s_rst) begin
            exp_q.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_val("hold_valid", valid, 1);
                check_val("hold_data", data, hold_data);
                check_val("hold_last", last, hold_last);
            end
            if (valid && ready) begin
                check_val("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_val("data", data, e[7:0]);
                    check_val("last", last, e[8]);
                end
                xfer_cnt++;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check_val("done_latency", cyc, last_xfer_cyc + 1);
            end
            hold_pending = valid && !ready;
            hold_data    = data;
            hold_last    = last;
        end
    end

    function automatic logic [7:0] m_fix(input logic [1:0] m, input logic [7:0] s);
        if (m == 2'd1 && s == 8'h00) return 8'h01;
        if (m == 2'd2 && $countones(s) != 1) return 8'h01;
        return s;
    endfunction

    function automatic logic [7:0] m_next(input logic [1:0] m, input logic [7:0] p, input logic [7:0] st);
        case (m)
            2'd0:    return p + st;
            2'd1:    return p[0] ? ((p >> 1) ^ 8'hB8) : (p >> 1);
            2'd2:    return (p << 1) | (p >> 7);
            default: return p;
        endcase
    endfunction

    task automatic push_model(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] st,
                              input int len);
        int n;
        logic [7:0] p;
        n = (len > 16) ? 16 : len;
        p = m_fix(m, sd);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, p});
            p = m_next(m, p, st);
        end
    endtask

    task automatic push_w(input logic [7:0] w, input logic l);
        exp_q.push_back({l, w});
    endtask

    // Requests one burst, drives the ready pattern (then 1) and waits for done.
    task automatic run_burst(input logic [1:0] m, input logic [7:0] sd, input logic [7:0] st,
                             input logic [4:0] len, input logic [7:0] rpat, input int rlen,
                             input bit spam, input int exp_xfers);
        int d0;
        int x0;
        int i;
        bit timed_out;
        d0 = done_cnt;
        x0 = xfer_cnt;
        timed_out = 1'b1;
        @(posedge clk_100); #1;
        start = 1'b1; mode = m; seed = sd; step = st; burst_len = len;
        @(posedge clk_100); #1;
        check_val("accept_busy", busy, 1);
        check_val("accept_valid", valid, 1);
        start = spam; mode = 2'd3; seed = 8'hAA; step = 8'h55; burst_len = 5'd2;
        i = 0;
        ready = (i < rlen) ? rpat[i] : 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk_100); #1;
            i++;
            ready = (i < rlen) ? rpat[i] : 1'b1;
            if (done) begin
                start = 1'b0;
                timed_out = 1'b0;
                break;
            end
        end
        check_val("burst_timeout", timed_out, 0);
        @(posedge clk_100); #1;
        check_val("idle_busy", busy, 0);
        check_val("idle_valid", valid, 0);
        check_val("idle_done", done, 0);
        check_val("done_count", done_cnt - d0, 1);
        check_val("xfer_count", xfer_cnt - x0, exp_xfers);
        check_val("sb_drained", exp_q.size(), 0);
        ready = 1'b0;
    endtask

    initial begin
        int d0;
        int x0;
        bit reached;
        // Reset values.
        repeat (3) @(posedge clk_100);
        #1;
        check_val("rst_valid", valid, 0);
        check_val("rst_data", data, 0);
        check_val("rst_last", last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        s_rst = 1'b0;

        // Zero-length start is ignored.
        start = 1'b1; burst_len = 5'd0; mode = 2'd0; seed = 8'h12;
        @(posedge clk_100); #1;
        start = 1'b0;
        repeat (2) begin
            check_val("len0_valid", valid, 0);
            check_val("len0_busy", busy, 0);
            @(posedge clk_100); #1;
        end

        // Counter wrap.
        push_w(8'hFE, 0); push_w(8'hFF, 0); push_w(8'h00, 0); push_w(8'h01, 1);
        run_burst(2'd0, 8'hFE, 8'h01, 5'd4, 8'h00, 0, 1'b0, 4);

        // LFSR from zero seed, walking-one from MSB.
        push_w(8'h01, 0); push_w(8'hB8, 0); push_w(8'h5C, 1);
        run_burst(2'd1, 8'h00, 8'h00, 5'd3, 8'h00, 0, 1'b0, 3);
        push_w(8'h80, 0); push_w(8'h01, 0); push_w(8'h02, 1);
        run_burst(2'd2, 8'h80, 8'h00, 5'd3, 8'h00, 0, 1'b0, 3);

        // Backpressure: ready 0,1,0,0,1,1.
        push_w(8'h05, 0); push_w(8'h08, 0); push_w(8'h0B, 1);
        run_burst(2'd0, 8'h05, 8'h03, 5'd3, 8'b0011_0010, 6, 1'b0, 3);

        // More patterns from the model: non-one-hot walking seed, LFSR, constant, step 0.
        push_model(2'd2, 8'h33, 8'h00, 10);
        run_burst(2'd2, 8'h33, 8'h00, 5'd10, 8'h00, 0, 1'b0, 10);
        push_model(2'd1, 8'h5A, 8'h00, 6);
        run_burst(2'd1, 8'h5A, 8'h00, 5'd6, 8'b0101_0101, 8, 1'b0, 6);
        push_model(2'd3, 8'hC3, 8'h07, 3);
        run_burst(2'd3, 8'hC3, 8'h07, 5'd3, 8'h00, 0, 1'b0, 3);
        push_model(2'd0, 8'h42, 8'h00, 2);
        run_burst(2'd0, 8'h42, 8'h00, 5'd2, 8'h00, 0, 1'b0, 2);

        // Start held high throughout a burst: no restart.
        push_model(2'd0, 8'h20, 8'h02, 5);
        run_burst(2'd0, 8'h20, 8'h02, 5'd5, 8'h00, 0, 1'b1, 5);

        // Length saturation.
        push_model(2'd0, 8'h00, 8'h01, 31);
        run_burst(2'd0, 8'h00, 8'h01, 5'd31, 8'h00, 0, 1'b0, 16);

        // Mid-burst reset after 2 of 8 words.
        d0 = done_cnt;
        x0 = xfer_cnt;
        push_model(2'd0, 8'h10, 8'h01, 8);
        @(posedge clk_100); #1;
        start = 1'b1; mode = 2'd0; seed = 8'h10; step = 8'h01; burst_len = 5'd8;
        @(posedge clk_100); #1;
        start = 1'b0;
        ready = 1'b1;
        reached = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk_100); #1;
            if (xfer_cnt - x0 >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        check_val("abort_reach", reached, 1);
        s_rst = 1'b1;
        ready = 1'b0;
        @(posedge clk_100); #1;
        check_val("abort_valid", valid, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_data", data, 0);
        check_val("abort_last", last, 0);
        s_rst = 1'b0;
        repeat (4) @(posedge clk_100);
        #1;
        check_val("abort_no_done", done_cnt - d0, 0);
        check_val("abort_xfers", xfer_cnt - x0, 2);
        push_model(2'd0, 8'h10, 8'h01, 3);
        run_burst(2'd0, 8'h10, 8'h01, 5'd3, 8'h00, 0, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_pattern_gen.md
# spi_pattern_gen

Parametrised stimulus source for the SPI transmitter bench: on a start pulse it emits a burst of `burst_len` words over a valid/ready handshake. Each word comes from one of four selectable patterns: counter with programmable step, LFSR, walking-one or constant. It sits between the bench controller and the SPI transmitter's parallel input, replacing the single-word counter former. It adds burst framing (`last`, `done`), a strict handshake and pattern modes.

## Interface
Parameters:
- `P_DATA_WIDTH`, 8: data word width, ≥ 2.
- `P_BURST_MAX`, 16: maximum burst length, ≥ 1.
- `P_LFSR_TAPS`, 8'hB8: Galois feedback mask, `P_DATA_WIDTH` bits wide.

Ports (`BW = $clog2(P_BURST_MAX+1)`):
- `clk_100`  in  1  single system clock; all logic on its rising edge.
- `s_rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  burst request, sampled only in IDLE.
- `mode`  in  2  pattern select, latched at accept: 0 counter, 1 LFSR, 2 walking-one, 3 constant.
- `seed`  in  P_DATA_WIDTH  first word value, latched at accept.
- `step`  in  P_DATA_WIDTH  counter increment, latched at accept.
- `burst_len`  in  BW  words per burst, latched at accept; values above P_BURST_MAX are saturated to P_BURST_MAX.
- `ready`  in  1  sink (SPI TX) can accept a word.
- `valid`  out  1  `data` holds a word.
- `data`  out  P_DATA_WIDTH  current word.
- `last`  out  1  high with the final word of a burst.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- FSM: IDLE → SEND → DONE → IDLE.
- **IDLE.** `start`=1 and `burst_len`≠0 is an accept:
  - latch mode, step and the saturated length;
  - load the pattern register with the seed value (see seed fixes);
  - clear the beat counter;
  - go to SEND.
- `start` with `burst_len`=0 is ignored.
- `start` outside IDLE is ignored, with no queuing.
- **SEND.** `valid`=1 and `data` = pattern register.
  - A transfer occurs on any cycle with `valid && ready`.
  - On a transfer, the beat counter increments and the pattern advances.
  - If that transfer was the final word, go to DONE.
- **Handshake rules.**
  - `data`/`last` hold stable while `valid && !ready`.
  - `valid` never drops before its transfer.
  - `ready` may toggle freely.
- `last` = SEND and beat counter = latched length − 1.
- **DONE.** `valid`=0, `done`=1 for one cycle, then IDLE.
- **Pattern advance.** All arithmetic is modulo 2^P_DATA_WIDTH.
  - Counter: p ← p + step. Wraps, e.g. 8'hFF + 1 → 8'h00. step=0 repeats the seed.
  - LFSR: p ← (p >> 1) ^ (p[0] ? P_LFSR_TAPS : 0).
  - Walking-one: rotate left by 1; the MSB wraps to bit 0.
  - Constant: p unchanged.
- **Seed fixes at load.**
  - LFSR with seed 0 loads 1, since an all-zero register would lock up.
  - Walking-one loads 1 whenever the seed is 0 or has more than one bit set.
  - A one-hot seed is loaded as is.
- **Reset.** `s_rst` has priority over everything, including mid-burst.
  - Next edge gives: state IDLE, `valid`=0, `data`=0, `last`=0, `busy`=0, `done`=0, beat counter 0, pattern register 0.
  - An aborted burst produces no `done`.
- `mode`/`seed`/`step`/`burst_len` changes during a burst have no effect.

## Timing
- Accept at edge k → `valid`, `busy` high after edge k, i.e. the first word is visible in cycle k+1.
- Throughput is one word per cycle while `ready`=1.
- N-word burst with `ready` held high: `valid` high for exactly N cycles, `done` in cycle N+1, IDLE in cycle N+2.
- Earliest next accept is in cycle N+2 (accept-to-accept gap N+2 cycles).
- All outputs are registered; no combinational path from `ready` or `start` to any output.

## Test plan
- **Reset values:** hold `s_rst` 3 cycles → all outputs 0. Then `start` with burst_len=0 → `valid` stays 0 and `busy` stays 0.
- **Counter wrap:** mode 0, seed=8'hFE, step=1, len=4, `ready`=1 → data FE, FF, 00, 01 on consecutive cycles. `last` is high only with 01, and `done` pulses in the next cycle.
- **LFSR and walking-one:**
  - mode 1, seed=0, len=3 → data 01, B8, 5C.
  - mode 2, seed=8'h80, len=3 → 80, 01, 02.
- **Backpressure:** mode 0, seed=5, step=3, len=3, `ready` pattern 0,1,0,0,1,1 → `data` holds 05 through the stall, then 08 holds two cycles, then 0B. Exactly 3 transfers occur, with `last` on 0B.
- **Ignored start and saturation:**
  - Pulse `start` every cycle mid-burst → no restart, single `done`.
  - burst_len=31 with P_BURST_MAX=16 → exactly 16 words.
- **Mid-burst reset:** assert `s_rst` after 2 of 8 words → next cycle `valid`=0, `busy`=0 and no `done`. A new burst then starts cleanly from its seed.
